// File: rtl/bp_cce_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bp_cce_pkg -- CCE directory opcodes, coherence encodings and width helper.
// Revision: 1.0
// ----------------------------------------------------------------------------
package bp_cce_pkg;

  localparam int bp_cce_coh_bits = 3;

  typedef enum logic [2:0] {
    e_rdp_op  = 3'd0,
    e_incp_op = 3'd1,
    e_decp_op = 3'd2,
    e_rde_op  = 3'd3,
    e_wde_op  = 3'd4,
    e_wds_op  = 3'd5,
    e_rdw_op  = 3'd6
  } bp_cce_dir_op_e;

  typedef enum logic [bp_cce_coh_bits-1:0] {
    e_COH_I = 3'd0,
    e_COH_S = 3'd1,
    e_COH_E = 3'd2,
    e_COH_M = 3'd3,
    e_COH_O = 3'd4
  } bp_coh_states_e;

  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_cce_dir_segmented_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bp_cce_dir_segmented_if -- command/result bus between decoder and directory.
// Revision: 1.0
// ----------------------------------------------------------------------------
interface bp_cce_dir_segmented_if #(
  parameter int num_way_groups_p = 8,
  parameter int num_lce_p        = 4,
  parameter int lce_assoc_p      = 2,
  parameter int tag_width_p      = 8,
  parameter int pending_width_p  = 2
);
  import bp_cce_pkg::*;

  localparam int c_WG_W  = safe_clog2(num_way_groups_p);
  localparam int c_LCE_W = safe_clog2(num_lce_p);
  localparam int c_WAY_W = safe_clog2(lce_assoc_p);

  logic                                 cmd_v_i;
  logic                                 cmd_ready_o;
  bp_cce_dir_op_e                       cmd_op_i;
  logic [c_WG_W-1:0]                    way_group_i;
  logic [c_LCE_W-1:0]                   lce_i;
  logic [c_WAY_W-1:0]                   way_i;
  logic [tag_width_p-1:0]               tag_i;
  logic [bp_cce_coh_bits-1:0]           coh_state_i;
  logic                                 pending_o;
  logic [pending_width_p-1:0]           pending_cnt_o;
  logic                                 entry_v_o;
  logic [tag_width_p-1:0]               tag_o;
  logic [bp_cce_coh_bits-1:0]           coh_state_o;
  logic                                 sharers_v_o;
  logic [num_lce_p-1:0]                 sharers_hits_o;
  logic [num_lce_p*c_WAY_W-1:0]         sharers_ways_o;
  logic [num_lce_p*bp_cce_coh_bits-1:0] sharers_coh_o;

  modport master (
    output cmd_v_i, cmd_op_i, way_group_i, lce_i, way_i, tag_i, coh_state_i,
    input  cmd_ready_o, pending_o, pending_cnt_o, entry_v_o, tag_o, coh_state_o,
    input  sharers_v_o, sharers_hits_o, sharers_ways_o, sharers_coh_o
  );

  modport slave (
    input  cmd_v_i, cmd_op_i, way_group_i, lce_i, way_i, tag_i, coh_state_i,
    output cmd_ready_o, pending_o, pending_cnt_o, entry_v_o, tag_o, coh_state_o,
    output sharers_v_o, sharers_hits_o, sharers_ways_o, sharers_coh_o
  );

endinterface
`default_nettype wire

// File: rtl/bp_cce_dir_tag_checker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bp_cce_dir_tag_checker -- per-LCE tag match over one directory RAM row.
// Revision: 1.0
// ----------------------------------------------------------------------------
module bp_cce_dir_tag_checker
  import bp_cce_pkg::*;
#(
  parameter int num_lce_p       = 4,
  parameter int lce_per_row_p   = 2,
  parameter int lce_assoc_p     = 2,
  parameter int tag_width_p     = 8,
  parameter int row_width_p     = lce_per_row_p * lce_assoc_p * (tag_width_p + bp_cce_coh_bits),
  parameter int row_idx_width_p = safe_clog2(num_lce_p / lce_per_row_p + 1),
  parameter int way_width_p     = safe_clog2(lce_assoc_p)
) (
  input  logic [row_width_p-1:0]               row_i,
  input  logic [tag_width_p-1:0]               tag_i,
  input  logic [row_idx_width_p-1:0]           row_idx_i,
  output logic [num_lce_p-1:0]                 hits_o,
  output logic [num_lce_p*way_width_p-1:0]     ways_o,
  output logic [num_lce_p*bp_cce_coh_bits-1:0] coh_o
);

  localparam int c_EW  = tag_width_p + bp_cce_coh_bits;
  localparam int c_TSW = lce_assoc_p * c_EW;

  always_comb begin
    logic [c_EW-1:0] entry;
    int              idx;
    hits_o = '0;
    ways_o = '0;
    coh_o  = '0;
    entry  = '0;
    idx    = 0;
    for (int l = 0; l < lce_per_row_p; l++) begin
      idx = int'(row_idx_i) * lce_per_row_p + l;
      // Scan high-to-low so the lowest-index hitting way is the one left standing.
      for (int w = lce_assoc_p - 1; w >= 0; w--) begin
        entry = row_i[l*c_TSW + w*c_EW +: c_EW];
        if (idx < num_lce_p && entry[bp_cce_coh_bits-1:0] != e_COH_I &&
            entry[c_EW-1:bp_cce_coh_bits] == tag_i) begin
          hits_o[idx]                                   = 1'b1;
          ways_o[idx*way_width_p +: way_width_p]        = way_width_p'(w);
          coh_o[idx*bp_cce_coh_bits +: bp_cce_coh_bits] = entry[bp_cce_coh_bits-1:0];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bsg_mem_1rw_sync_mask_write_bit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bsg_mem_1rw_sync_mask_write_bit -- single-port sync RAM, bit-masked writes.
// Revision: 1.0
// ----------------------------------------------------------------------------
module bsg_mem_1rw_sync_mask_write_bit
  import bp_cce_pkg::*;
#(
  parameter int width_p       = 8,
  parameter int els_p         = 4,
  parameter int addr_width_lp = safe_clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic                     v_i,
  input  logic [width_p-1:0]       w_mask_i,
  input  logic                     w_i,
  output logic [width_p-1:0]       data_o
);

  logic [width_p-1:0] mem_q [els_p];
  logic [width_p-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (v_i) begin
      if (w_i) mem_q[addr_i] <= (mem_q[addr_i] & ~w_mask_i) | (data_i & w_mask_i);
      else     data_q        <= mem_q[addr_i];
    end
  end

  assign data_o = data_q;

endmodule
`default_nettype wire

// File: rtl/bp_cce_dir_segmented.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bp_cce_dir_segmented -- CCE coherence directory, way-groups split over rows.
// Revision: 1.0
// ----------------------------------------------------------------------------
module bp_cce_dir_segmented
  import bp_cce_pkg::*;
#(
  parameter int num_way_groups_p = 8,
  parameter int num_lce_p        = 4,
  parameter int lce_assoc_p      = 2,
  parameter int tag_width_p      = 8,
  parameter int lce_per_row_p    = 2,
  parameter int pending_width_p  = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  bp_cce_dir_segmented_if.slave dir_if
);

  localparam int c_ROWS   = num_lce_p / lce_per_row_p;
  localparam int c_ELS    = num_way_groups_p * c_ROWS;
  localparam int c_EW     = tag_width_p + bp_cce_coh_bits;
  localparam int c_TSW    = lce_assoc_p * c_EW;
  localparam int c_ROW_W  = lce_per_row_p * c_TSW;
  localparam int c_ADDR_W = safe_clog2(c_ELS);
  localparam int c_CNT_W  = safe_clog2(c_ROWS + 1);
  localparam int c_WG_W   = safe_clog2(num_way_groups_p);
  localparam int c_WAY_W  = safe_clog2(lce_assoc_p);
  localparam int c_SLOT_W = safe_clog2(lce_per_row_p);
  localparam logic [pending_width_p-1:0] c_PEND_MAX = '1;
  localparam logic [pending_width_p-1:0] c_PEND_ONE = pending_width_p'(1);

  localparam logic [1:0] e_init  = 2'd0;
  localparam logic [1:0] e_ready = 2'd1;
  localparam logic [1:0] e_rdw   = 2'd2;

  logic [1:0]                           state_q, state_d;
  logic [c_ADDR_W-1:0]                  init_row_q;
  logic [c_CNT_W-1:0]                   rdw_cnt_q;
  logic [c_WG_W-1:0]                    wg_q;
  logic [tag_width_p-1:0]               tag_q;
  logic [c_SLOT_W-1:0]                  rde_slot_q;
  logic [c_WAY_W-1:0]                   rde_way_q;
  logic                                 entry_v_q, sharers_v_q;
  logic [num_lce_p-1:0]                 hits_q;
  logic [num_lce_p*c_WAY_W-1:0]         ways_q;
  logic [num_lce_p*bp_cce_coh_bits-1:0] coh_q;
  logic [pending_width_p-1:0]           pend_q [num_way_groups_p];

  logic                                 w_accept;
  logic [c_ADDR_W-1:0]                  w_cmd_addr, w_rdw_addr, w_mem_addr;
  logic [c_SLOT_W-1:0]                  w_cmd_slot;
  logic [31:0]                          w_cmd_off, w_rde_off;
  logic                                 w_mem_v, w_mem_w;
  logic [c_ROW_W-1:0]                   w_mem_data, w_mem_mask, w_mem_q;
  logic [c_EW-1:0]                      w_rde_entry;
  logic [num_lce_p-1:0]                 w_chk_hits;
  logic [num_lce_p*c_WAY_W-1:0]         w_chk_ways;
  logic [num_lce_p*bp_cce_coh_bits-1:0] w_chk_coh;
  logic [pending_width_p-1:0]           w_pend_sel;

  assign dir_if.cmd_ready_o = (state_q == e_ready);
  assign w_accept   = dir_if.cmd_v_i & dir_if.cmd_ready_o;
  assign w_cmd_slot = c_SLOT_W'(dir_if.lce_i % lce_per_row_p);
  assign w_cmd_addr = c_ADDR_W'(dir_if.way_group_i * c_ROWS + dir_if.lce_i / lce_per_row_p);
  assign w_rdw_addr = c_ADDR_W'(wg_q * c_ROWS + 32'(rdw_cnt_q));
  assign w_cmd_off  = 32'(w_cmd_slot) * c_TSW + 32'(dir_if.way_i) * c_EW;
  assign w_rde_off  = 32'(rde_slot_q) * c_TSW + 32'(rde_way_q) * c_EW;

  always_comb begin
    state_d    = state_q;
    w_mem_v    = 1'b0;
    w_mem_w    = 1'b0;
    w_mem_addr = w_cmd_addr;
    w_mem_data = '0;
    w_mem_mask = '0;
    case (state_q)
      e_init: begin
        w_mem_v    = 1'b1;
        w_mem_w    = 1'b1;
        w_mem_addr = init_row_q;
        w_mem_mask = '1;
        if (init_row_q == c_ADDR_W'(c_ELS - 1)) state_d = e_ready;
      end
      e_ready: begin
        if (w_accept) begin
          case (dir_if.cmd_op_i)
            e_wde_op: begin
              w_mem_v    = 1'b1;
              w_mem_w    = 1'b1;
              w_mem_data = c_ROW_W'({dir_if.tag_i, dir_if.coh_state_i}) << w_cmd_off;
              w_mem_mask = c_ROW_W'({c_EW{1'b1}}) << w_cmd_off;
            end
            e_wds_op: begin
              w_mem_v    = 1'b1;
              w_mem_w    = 1'b1;
              w_mem_data = c_ROW_W'(dir_if.coh_state_i) << w_cmd_off;
              w_mem_mask = c_ROW_W'({bp_cce_coh_bits{1'b1}}) << w_cmd_off;
            end
            e_rde_op: w_mem_v = 1'b1;
            e_rdw_op: begin
              w_mem_v    = 1'b1;
              w_mem_addr = c_ADDR_W'(dir_if.way_group_i * c_ROWS);
              state_d    = e_rdw;
            end
            default: ;
          endcase
        end
      end
      e_rdw: begin
        // Row 0 went out with the accept; rows 1..c_ROWS-1 follow back to back.
        if (rdw_cnt_q < c_CNT_W'(c_ROWS)) begin
          w_mem_v    = 1'b1;
          w_mem_addr = w_rdw_addr;
        end
        if (rdw_cnt_q == c_CNT_W'(c_ROWS)) state_d = e_ready;
      end
      default: state_d = e_init;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= e_init;
      init_row_q  <= '0;
      rdw_cnt_q   <= '0;
      wg_q        <= '0;
      tag_q       <= '0;
      rde_slot_q  <= '0;
      rde_way_q   <= '0;
      entry_v_q   <= 1'b0;
      sharers_v_q <= 1'b0;
      hits_q      <= '0;
      ways_q      <= '0;
      coh_q       <= '0;
      for (int i = 0; i < num_way_groups_p; i++) pend_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      entry_v_q   <= w_accept && (dir_if.cmd_op_i == e_rde_op);
      sharers_v_q <= (state_q == e_rdw) && (rdw_cnt_q == c_CNT_W'(c_ROWS));
      if (state_q == e_init) init_row_q <= init_row_q + c_ADDR_W'(1);
      if (w_accept) begin
        case (dir_if.cmd_op_i)
          e_rde_op: begin
            rde_slot_q <= w_cmd_slot;
            rde_way_q  <= dir_if.way_i;
          end
          e_rdw_op: begin
            wg_q      <= dir_if.way_group_i;
            tag_q     <= dir_if.tag_i;
            rdw_cnt_q <= c_CNT_W'(1);
            hits_q    <= '0;
            ways_q    <= '0;
            coh_q     <= '0;
          end
          e_incp_op: if (w_pend_sel != c_PEND_MAX) pend_q[dir_if.way_group_i] <= w_pend_sel + c_PEND_ONE;
          e_decp_op: if (w_pend_sel != '0)         pend_q[dir_if.way_group_i] <= w_pend_sel - c_PEND_ONE;
          default: ;
        endcase
      end
      if (state_q == e_rdw) begin
        rdw_cnt_q <= rdw_cnt_q + c_CNT_W'(1);
        hits_q    <= hits_q | w_chk_hits;
        ways_q    <= ways_q | w_chk_ways;
        coh_q     <= coh_q  | w_chk_coh;
      end
    end
  end

  bsg_mem_1rw_sync_mask_write_bit #(
    .width_p (c_ROW_W),
    .els_p   (c_ELS)
  ) dir_ram (
    .clk_i    (clk_i),
    .data_i   (w_mem_data),
    .addr_i   (w_mem_addr),
    .v_i      (w_mem_v),
    .w_mask_i (w_mem_mask),
    .w_i      (w_mem_w),
    .data_o   (w_mem_q)
  );

  bp_cce_dir_tag_checker #(
    .num_lce_p     (num_lce_p),
    .lce_per_row_p (lce_per_row_p),
    .lce_assoc_p   (lce_assoc_p),
    .tag_width_p   (tag_width_p)
  ) tag_checker (
    .row_i     (w_mem_q),
    .tag_i     (tag_q),
    .row_idx_i (rdw_cnt_q - c_CNT_W'(1)),
    .hits_o    (w_chk_hits),
    .ways_o    (w_chk_ways),
    .coh_o     (w_chk_coh)
  );

  assign w_pend_sel            = pend_q[dir_if.way_group_i];
  assign dir_if.pending_cnt_o  = w_pend_sel;
  assign dir_if.pending_o      = |w_pend_sel;
  assign w_rde_entry           = c_EW'(w_mem_q >> w_rde_off);
  assign dir_if.entry_v_o      = entry_v_q;
  assign dir_if.tag_o          = entry_v_q ? w_rde_entry[c_EW-1:bp_cce_coh_bits] : '0;
  assign dir_if.coh_state_o    = entry_v_q ? w_rde_entry[bp_cce_coh_bits-1:0] : '0;
  assign dir_if.sharers_v_o    = sharers_v_q;
  assign dir_if.sharers_hits_o = hits_q;
  assign dir_if.sharers_ways_o = ways_q;
  assign dir_if.sharers_coh_o  = coh_q;

endmodule
`default_nettype wire

// File: tb/tb_bp_cce_dir_segmented.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bp_cce_dir_segmented -- randomized bench against a directory array model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_bp_cce_dir_segmented;
  import bp_cce_pkg::*;

  localparam int NWG   = 8;
  localparam int NLCE  = 4;
  localparam int ASSOC = 2;
  localparam int TAGW  = 8;
  localparam int LPR   = 2;
  localparam int PW    = 2;
  localparam int ROWS  = NLCE / LPR;
  localparam int ELS   = NWG * ROWS;
  localparam int PMAX  = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bp_cce_dir_segmented_if #(
    .num_way_groups_p(NWG), .num_lce_p(NLCE), .lce_assoc_p(ASSOC),
    .tag_width_p(TAGW), .pending_width_p(PW)
  ) dif ();

  bp_cce_dir_segmented #(
    .num_way_groups_p(NWG), .num_lce_p(NLCE), .lce_assoc_p(ASSOC),
    .tag_width_p(TAGW), .lce_per_row_p(LPR), .pending_width_p(PW)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .dir_if  (dif)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [TAGW-1:0] m_tag [NWG][NLCE][ASSOC];
  logic [2:0]      m_coh [NWG][NLCE][ASSOC];
  int              m_pend [NWG];

  task automatic model_clear();
    for (int g = 0; g < NWG; g++) begin
      m_pend[g] = 0;
      for (int l = 0; l < NLCE; l++)
        for (int w = 0; w < ASSOC; w++) begin
          m_tag[g][l][w] = '0;
          m_coh[g][l][w] = '0;
        end
    end
  endtask

  // Drives one command, waits for acceptance, returns at accept-edge + 1.
  task automatic issue(input bp_cce_dir_op_e op, input int wg, input int lce, input int way,
                       input logic [TAGW-1:0] tag, input logic [2:0] coh);
    int budget;
    budget = 0;
    @(negedge clk);
    dif.cmd_v_i     = 1'b1;
    dif.cmd_op_i    = op;
    dif.way_group_i = 3'(wg);
    dif.lce_i       = 2'(lce);
    dif.way_i       = 1'(way);
    dif.tag_i       = tag;
    dif.coh_state_i = coh;
    while (dif.cmd_ready_o !== 1'b1 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (dif.cmd_ready_o !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout ready=%b required=1", dif.cmd_ready_o);
    end
    @(posedge clk);
    #1;
    dif.cmd_v_i = 1'b0;
    case (op)
      e_wde_op: begin
        m_tag[wg][lce][way] = tag;
        m_coh[wg][lce][way] = coh;
      end
      e_wds_op:  m_coh[wg][lce][way] = coh;
      e_incp_op: if (m_pend[wg] < PMAX) m_pend[wg]++;
      e_decp_op: if (m_pend[wg] > 0) m_pend[wg]--;
      default: ;
    endcase
  endtask

  task automatic test_reset();
    int cyc;
    cyc = 0;
    rst = 1'b1;
    dif.cmd_v_i = 1'b0; dif.cmd_op_i = e_rdp_op; dif.way_group_i = '0;
    dif.lce_i = '0; dif.way_i = '0; dif.tag_i = '0; dif.coh_state_i = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (dif.cmd_ready_o !== 1'b0) begin miscompares++; $display("FAIL rst_ready got=%b want=0", dif.cmd_ready_o); end
    vectors++; if (dif.entry_v_o !== 1'b0) begin miscompares++; $display("FAIL rst_entry_v got=%b want=0", dif.entry_v_o); end
    vectors++; if (dif.sharers_v_o !== 1'b0) begin miscompares++; $display("FAIL rst_sharers_v got=%b want=0", dif.sharers_v_o); end
    vectors++; if (dif.sharers_hits_o !== '0) begin miscompares++; $display("FAIL rst_hits got=%b want=0", dif.sharers_hits_o); end
    vectors++; if (dif.pending_cnt_o !== '0) begin miscompares++; $display("FAIL rst_pending got=%0d want=0", dif.pending_cnt_o); end
    @(negedge clk);
    rst = 1'b0;
    while (dif.cmd_ready_o !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    vectors++; if (cyc != ELS) begin miscompares++; $display("FAIL init_latency got=%0d want=%0d", cyc, ELS); end
    model_clear();
  endtask

  task automatic test_init_read();
    for (int i = 0; i < 6; i++) begin
      int g, l, w;
      g = $urandom_range(0, NWG-1); l = $urandom_range(0, NLCE-1); w = $urandom_range(0, ASSOC-1);
      issue(e_rde_op, g, l, w, '0, '0);
      vectors++; if (dif.entry_v_o !== 1'b1) begin miscompares++; $display("FAIL init_rde_v got=%b want=1", dif.entry_v_o); end
      vectors++; if (dif.tag_o !== '0 || dif.coh_state_o !== '0) begin
        miscompares++; $display("FAIL init_rde got=%h/%0d want=0/0", dif.tag_o, dif.coh_state_o); end
    end
  endtask

  task automatic test_rdw();
    for (int r = 0; r < 10; r++) begin
      int g;
      logic [TAGW-1:0]  t;
      logic [NLCE-1:0]  eh;
      int ew [NLCE];
      int ec [NLCE];
      if (r == 0) begin
        g = 5; t = 8'h11;
        issue(e_wde_op, g, 0, 1, 8'h11, 3'd1);
        issue(e_wde_op, g, 2, 0, 8'h11, 3'd2);
        issue(e_wde_op, g, 2, 1, 8'h11, 3'd3);
        issue(e_wde_op, g, 3, 0, 8'h11, 3'd0);
      end else begin
        g = $urandom_range(0, NWG-1);
        t = ($urandom_range(0, 1) == 1) ? 8'h11 : 8'h22;
        repeat (6) issue(e_wde_op, g, $urandom_range(0, NLCE-1), $urandom_range(0, ASSOC-1),
                         ($urandom_range(0, 1) == 1) ? 8'h11 : 8'h22, 3'($urandom_range(0, 4)));
      end
      eh = '0;
      for (int l = 0; l < NLCE; l++) begin
        ew[l] = 0; ec[l] = 0;
        for (int w = 0; w < ASSOC; w++)
          if (!eh[l] && m_coh[g][l][w] != 0 && m_tag[g][l][w] == t) begin
            eh[l] = 1'b1; ew[l] = w; ec[l] = m_coh[g][l][w];
          end
      end
      issue(e_rdw_op, g, 0, 0, t, '0);
      for (int c = 1; c <= ROWS + 1; c++) begin
        vectors++; if (dif.sharers_v_o !== (c == ROWS + 1)) begin
          miscompares++; $display("FAIL rdw_valid cycle=%0d got=%b want=%b", c, dif.sharers_v_o, (c == ROWS + 1)); end
        vectors++; if (dif.cmd_ready_o !== (c == ROWS + 1)) begin
          miscompares++; $display("FAIL rdw_ready cycle=%0d got=%b want=%b", c, dif.cmd_ready_o, (c == ROWS + 1)); end
        if (c <= ROWS) begin @(posedge clk); #1; end
      end
      vectors++; if (dif.sharers_hits_o !== eh) begin
        miscompares++; $display("FAIL rdw_hits round=%0d got=%b want=%b", r, dif.sharers_hits_o, eh); end
      for (int l = 0; l < NLCE; l++) begin
        vectors++; if (dif.sharers_ways_o[l +: 1] !== 1'(ew[l]) || dif.sharers_coh_o[l*3 +: 3] !== 3'(ec[l])) begin
          miscompares++; $display("FAIL rdw_lce%0d round=%0d got=%0d/%0d want=%0d/%0d", l, r,
                                  dif.sharers_ways_o[l +: 1], dif.sharers_coh_o[l*3 +: 3], ew[l], ec[l]); end
      end
      if (r == 0) begin
        vectors++; if (dif.sharers_hits_o !== 4'b0101 || dif.sharers_ways_o[0] !== 1'b1 || dif.sharers_ways_o[2] !== 1'b0) begin
          miscompares++; $display("FAIL rdw_directed got=%b/%b want=0101/xx0x1", dif.sharers_hits_o, dif.sharers_ways_o); end
      end
      @(posedge clk);
      #1;
      vectors++; if (dif.sharers_v_o !== 1'b0 || dif.sharers_hits_o !== eh) begin
        miscompares++; $display("FAIL rdw_hold got=%b/%b want=0/%b", dif.sharers_v_o, dif.sharers_hits_o, eh); end
    end
  endtask

  task automatic test_wde_wds();
    issue(e_wde_op, 3, 2, 1, 8'h5A, 3'd2);
    issue(e_rde_op, 3, 2, 1, '0, '0);
    vectors++; if (dif.entry_v_o !== 1'b1 || dif.tag_o !== 8'h5A || dif.coh_state_o !== 3'd2) begin
      miscompares++; $display("FAIL wde_rde got=%b/%h/%0d want=1/5a/2", dif.entry_v_o, dif.tag_o, dif.coh_state_o); end
    @(posedge clk);
    #1;
    vectors++; if (dif.entry_v_o !== 1'b0) begin miscompares++; $display("FAIL rde_pulse got=%b want=0", dif.entry_v_o); end
    issue(e_wds_op, 3, 2, 1, 8'hFF, 3'd1);
    issue(e_rde_op, 3, 2, 1, '0, '0);
    vectors++; if (dif.tag_o !== 8'h5A || dif.coh_state_o !== 3'd1) begin
      miscompares++; $display("FAIL wds_rde got=%h/%0d want=5a/1", dif.tag_o, dif.coh_state_o); end
    for (int i = 0; i < 40; i++) begin
      int g, l, w;
      g = $urandom_range(0, NWG-1); l = $urandom_range(0, NLCE-1); w = $urandom_range(0, ASSOC-1);
      issue(($urandom_range(0, 2) == 0) ? e_wds_op : e_wde_op, g, l, w, 8'($urandom), 3'($urandom_range(0, 4)));
      if ($urandom_range(0, 1) == 1) begin
        g = $urandom_range(0, NWG-1); l = $urandom_range(0, NLCE-1); w = $urandom_range(0, ASSOC-1);
      end
      issue(e_rde_op, g, l, w, '0, '0);
      vectors++; if (dif.entry_v_o !== 1'b1 || dif.tag_o !== m_tag[g][l][w] || dif.coh_state_o !== m_coh[g][l][w]) begin
        miscompares++; $display("FAIL rand_rde wg=%0d lce=%0d way=%0d got=%h/%0d want=%h/%0d", g, l, w,
                                dif.tag_o, dif.coh_state_o, m_tag[g][l][w], m_coh[g][l][w]); end
    end
  endtask

  task automatic test_pending();
    repeat (5) issue(e_incp_op, 7, 0, 0, '0, '0);
    @(negedge clk); dif.way_group_i = 3'd7; #1;
    vectors++; if (dif.pending_cnt_o !== 2'd3 || dif.pending_o !== 1'b1) begin
      miscompares++; $display("FAIL incp_sat got=%0d/%b want=3/1", dif.pending_cnt_o, dif.pending_o); end
    dif.way_group_i = 3'd6; #1;
    vectors++; if (dif.pending_cnt_o !== 2'(m_pend[6])) begin
      miscompares++; $display("FAIL pend_other got=%0d want=%0d", dif.pending_cnt_o, m_pend[6]); end
    repeat (4) issue(e_decp_op, 7, 0, 0, '0, '0);
    @(negedge clk); dif.way_group_i = 3'd7; #1;
    vectors++; if (dif.pending_cnt_o !== 2'd0 || dif.pending_o !== 1'b0) begin
      miscompares++; $display("FAIL decp_floor got=%0d/%b want=0/0", dif.pending_cnt_o, dif.pending_o); end
    for (int i = 0; i < 40; i++) begin
      int g, k;
      bp_cce_dir_op_e op;
      k = $urandom_range(0, 2);
      op = (k == 0) ? e_incp_op : (k == 1) ? e_decp_op : e_rdp_op;
      issue(op, $urandom_range(0, 3), 0, 0, '0, '0);
      g = $urandom_range(0, NWG-1);
      @(negedge clk); dif.way_group_i = 3'(g); #1;
      vectors++; if (dif.pending_cnt_o !== 2'(m_pend[g]) || dif.pending_o !== (m_pend[g] != 0)) begin
        miscompares++; $display("FAIL rand_pend wg=%0d got=%0d/%b want=%0d", g, dif.pending_cnt_o, dif.pending_o, m_pend[g]); end
    end
  endtask

  task automatic test_reset_mid_rdw();
    int cyc;
    cyc = 0;
    issue(e_incp_op, 1, 0, 0, '0, '0);
    issue(e_incp_op, 2, 0, 0, '0, '0);
    issue(e_wde_op, 4, 1, 0, 8'h33, 3'd1);
    issue(e_rdw_op, 4, 0, 0, 8'h33, '0);
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      vectors++; if (dif.sharers_v_o !== 1'b0 || dif.cmd_ready_o !== 1'b0) begin
        miscompares++; $display("FAIL abort_rdw cycle=%0d got=%b/%b want=0/0", c, dif.sharers_v_o, dif.cmd_ready_o); end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rst = 1'b0;
    while (dif.cmd_ready_o !== 1'b1 && cyc < 200) begin
      vectors++; if (dif.sharers_v_o !== 1'b0) begin miscompares++; $display("FAIL reinit_sharers_v got=%b want=0", dif.sharers_v_o); end
      @(posedge clk);
      #1;
      cyc++;
    end
    vectors++; if (cyc != ELS) begin miscompares++; $display("FAIL reinit_latency got=%0d want=%0d", cyc, ELS); end
    model_clear();
    vectors++; if (dif.sharers_hits_o !== '0) begin miscompares++; $display("FAIL reinit_hits got=%b want=0", dif.sharers_hits_o); end
    for (int g = 0; g < NWG; g++) begin
      dif.way_group_i = 3'(g); #1;
      vectors++; if (dif.pending_cnt_o !== 2'(m_pend[g])) begin
        miscompares++; $display("FAIL reinit_pend wg=%0d got=%0d want=0", g, dif.pending_cnt_o); end
    end
    issue(e_rde_op, 4, 1, 0, '0, '0);
    vectors++; if (dif.tag_o !== '0 || dif.coh_state_o !== '0) begin
      miscompares++; $display("FAIL reinit_rde got=%h/%0d want=0/0", dif.tag_o, dif.coh_state_o); end
  endtask

  initial begin
    test_reset();
    test_init_read();
    test_rdw();
    test_wde_wds();
    test_pending();
    test_reset_mid_rdw();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time=%0t limit=2000000", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
